// File: rtl/tone_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tone_detector
//  Brief    : Measures the period of a 1-bit square-wave tone and reports
//             which jingle note (or silence / unknown) it is.
//  Revision : 1.0  initial release
// ============================================================================
module tone_detector #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned MIN_FREQ  = 200,
   parameter int unsigned MAX_FREQ  = 2000,
   parameter int unsigned STABLE_N  = 3,
   parameter int unsigned TOL_SHIFT = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tone_in,
   output logic        note_valid,
   output logic [3:0]  note_code,
   output logic [31:0] period,
   output logic        tone_active
);

   localparam logic [31:0] c_timeout    = 32'(CLK_FREQ / MIN_FREQ);
   localparam logic [31:0] c_min_period = 32'(CLK_FREQ / MAX_FREQ);
   localparam int          c_num_notes  = 7;
   localparam logic [3:0]  c_code_unk   = 4'd15;
   localparam int          c_cw         = $clog2(STABLE_N + 1);
   localparam logic [c_cw-1:0] c_stable = c_cw'(STABLE_N);

   function automatic int unsigned note_freq(input int k);
      case (k)
         0:       return 415;
         1:       return 523;
         2:       return 554;
         3:       return 622;
         4:       return 698;
         5:       return 740;
         default: return 830;
      endcase
   endfunction

   typedef enum logic [0:0] {SILENT = 1'b0, TRACKING = 1'b1} state_t;

   state_t            r_state;
   logic              r_sync1, r_sync2, r_hist, r_rise;
   logic [31:0]       r_cnt;
   logic              r_cls_valid;
   logic [3:0]        r_cls_code;
   logic [31:0]       r_cls_meas;
   logic [3:0]        r_cand;
   logic [c_cw-1:0]   r_cand_cnt;

   logic              w_rise;
   logic [31:0]       w_meas;
   logic [c_num_notes-1:0] w_match;
   logic [3:0]        w_code;
   logic [3:0]        w_next_cand;
   logic [c_cw-1:0]   w_next_cc;

   assign w_rise      = r_sync2 & ~r_hist;
   assign w_meas      = r_cnt + 32'd1;
   assign tone_active = (r_state == TRACKING);

   // One window comparator per table entry; nominal periods fold to constants.
   generate
      for (genvar k = 0; k < c_num_notes; k++) begin : g_note
         localparam logic [31:0] c_nom = 32'(CLK_FREQ / note_freq(k));
         localparam logic [32:0] c_tol = {1'b0, c_nom >> TOL_SHIFT};
         logic signed [32:0] w_diff;
         logic [32:0]        w_abs;
         assign w_diff     = $signed({1'b0, w_meas}) - $signed({1'b0, c_nom});
         assign w_abs      = w_diff[32] ? $unsigned(-w_diff) : $unsigned(w_diff);
         assign w_match[k] = (w_abs <= c_tol);
      end
   endgenerate

   always_comb begin
      w_code = c_code_unk;
      if (w_meas >= c_min_period) begin
         for (int k = c_num_notes - 1; k >= 0; k--) begin
            if (w_match[k]) w_code = 4'(k + 1);
         end
      end
   end

   always_comb begin
      w_next_cand = r_cls_code;
      w_next_cc   = c_cw'(1);
      if (r_cls_code == r_cand)
         w_next_cc = (r_cand_cnt >= c_stable) ? c_stable : r_cand_cnt + c_cw'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= SILENT;
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_hist      <= 1'b0;
         r_rise      <= 1'b0;
         r_cnt       <= '0;
         r_cls_valid <= 1'b0;
         r_cls_code  <= '0;
         r_cls_meas  <= '0;
         r_cand      <= '0;
         r_cand_cnt  <= '0;
         note_valid  <= 1'b0;
         note_code   <= '0;
         period      <= '0;
      end else begin
         r_sync1     <= tone_in;
         r_sync2     <= r_sync1;
         r_hist      <= r_sync2;
         r_rise      <= w_rise;
         note_valid  <= 1'b0;
         r_cls_valid <= 1'b0;
         case (r_state)
            SILENT: begin
               r_cnt <= '0;
               if (r_rise) begin
                  r_state    <= TRACKING;
                  r_cand_cnt <= '0;
               end
            end
            default: begin
               // A rise on the timeout cycle still counts as a period.
               if (r_rise) begin
                  r_cnt       <= '0;
                  r_cls_valid <= 1'b1;
                  r_cls_code  <= w_code;
                  r_cls_meas  <= w_meas;
               end else if (r_cnt >= c_timeout) begin
                  r_state <= SILENT;
                  r_cnt   <= '0;
                  if (note_code != 4'd0) begin
                     note_code  <= 4'd0;
                     period     <= '0;
                     note_valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
         endcase
         if (r_cls_valid) begin
            r_cand     <= w_next_cand;
            r_cand_cnt <= w_next_cc;
            if (w_next_cc == c_stable && w_next_cand != note_code) begin
               note_code  <= w_next_cand;
               period     <= r_cls_meas;
               note_valid <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tone_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tone_detector
//  Brief    : Randomized bench for tone_detector with an event-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tone_detector;

   localparam int unsigned CLK_FREQ  = 250_000;
   localparam int unsigned MIN_FREQ  = 200;
   localparam int unsigned MAX_FREQ  = 2000;
   localparam int unsigned STABLE_N  = 3;
   localparam int unsigned TOL_SHIFT = 6;
   localparam int          T         = CLK_FREQ / MIN_FREQ;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tone_in = 1'b0;
   logic        note_valid;
   logic [3:0]  note_code;
   logic [31:0] period;
   logic        tone_active;

   always #5 clk = ~clk;

   tone_detector #(
      .CLK_FREQ(CLK_FREQ), .MIN_FREQ(MIN_FREQ), .MAX_FREQ(MAX_FREQ),
      .STABLE_N(STABLE_N), .TOL_SHIFT(TOL_SHIFT)
   ) dut (
      .clk(clk), .reset(reset), .tone_in(tone_in), .note_valid(note_valid),
      .note_code(note_code), .period(period), .tone_active(tone_active)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int nom(input int k);
      int f;
      case (k)
         1: f = 415; 2: f = 523; 3: f = 554; 4: f = 622;
         5: f = 698; 6: f = 740; default: f = 830;
      endcase
      return int'(CLK_FREQ) / f;
   endfunction

   function automatic logic [3:0] classify(input int meas);
      int d;
      if (meas < int'(CLK_FREQ / MAX_FREQ)) return 4'd15;
      for (int k = 1; k <= 7; k++) begin
         d = meas - nom(k);
         if (d < 0) d = -d;
         if (d <= (nom(k) >> TOL_SHIFT)) return 4'(k);
      end
      return 4'd15;
   endfunction

   // Model: output changes keyed by the clock edge on which they appear.
   typedef struct {
      bit          pulse;
      bit          upd_note;
      logic [3:0]  code;
      logic [31:0] per;
      bit          upd_act;
      bit          act;
   } ev_t;
   ev_t evq[int];

   bit         m_armed;
   int         m_last;
   bit         m_prev;
   logic [3:0] m_run_code;
   int         m_run_len;
   logic [3:0] m_cur;
   int         rise_cyc[$];

   task automatic add_ev(input int at, input ev_t e);
      ev_t o;
      if (evq.exists(at)) begin
         o = evq[at];
         o.pulse = o.pulse | e.pulse;
         if (e.upd_note) begin o.upd_note = 1; o.code = e.code; o.per = e.per; end
         if (e.upd_act)  begin o.upd_act = 1;  o.act = e.act; end
         evq[at] = o;
      end else begin
         evq[at] = e;
      end
   endtask

   task automatic model_reset();
      m_armed = 0; m_last = 0; m_prev = 0;
      m_run_code = 0; m_run_len = 0; m_cur = 0;
      evq.delete();
   endtask

   task automatic model_pin(input int n, input logic pin);
      ev_t e;
      int  meas;
      logic [3:0] c;
      if (m_armed && (n - m_last) >= T + 2) begin
         m_armed = 0;
         e = '{default: 0};
         e.upd_act = 1; e.act = 0;
         if (m_cur != 0) begin
            e.pulse = 1; e.upd_note = 1; e.code = 0; e.per = 0;
            m_cur = 0;
         end
         add_ev(m_last + T + 5, e);
      end
      if (pin && !m_prev) begin
         if (!m_armed) begin
            m_armed = 1; m_last = n; m_run_len = 0;
            e = '{default: 0};
            e.upd_act = 1; e.act = 1;
            add_ev(n + 4, e);
         end else begin
            meas = n - m_last;
            m_last = n;
            c = classify(meas);
            if (m_run_len > 0 && c == m_run_code) m_run_len++;
            else begin m_run_code = c; m_run_len = 1; end
            if (m_run_len >= int'(STABLE_N) && c != m_cur) begin
               m_cur = c;
               e = '{default: 0};
               e.pulse = 1; e.upd_note = 1; e.code = c; e.per = 32'(meas);
               add_ev(n + 5, e);
            end
         end
      end
      m_prev = pin;
   endtask

   logic [3:0]  e_code = 0;
   logic [31:0] e_per  = 0;
   bit          e_act  = 0;
   int          pulses = 0;
   int          last_pulse_cyc = 0;

   always @(negedge clk) begin
      bit ep;
      ep = 0;
      if (reset) begin
         e_code = 0; e_per = 0; e_act = 0;
      end else if (evq.exists(cyc)) begin
         ep = evq[cyc].pulse;
         if (evq[cyc].upd_note) begin e_code = evq[cyc].code; e_per = evq[cyc].per; end
         if (evq[cyc].upd_act) e_act = evq[cyc].act;
         evq.delete(cyc);
      end
      chk("note_valid",  32'(note_valid),  32'(ep));
      chk("note_code",   32'(note_code),   32'(e_code));
      chk("period",      period,           e_per);
      chk("tone_active", 32'(tone_active), 32'(e_act));
      if (note_valid) begin
         pulses++;
         last_pulse_cyc = cyc;
      end
   end

   task automatic drive(input logic lvl);
      @(posedge clk);
      #1;
      tone_in = lvl;
      if (!reset) model_pin(cyc, lvl);
   endtask

   task automatic tone(input int per, input int n);
      repeat (n) begin
         for (int i = 0; i < per; i++) begin
            drive(i < per / 2);
            if (i == 0) rise_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic quiet(input int n);
      repeat (n) drive(1'b0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      tone_in = 1'b0;
      reset   = 1'b0;
      model_reset();
   endtask

   initial begin
      int p0, k, per, n, tol, g;
      model_reset();

      // Reset held with a toggling pin, then fewer than four rises.
      for (int i = 0; i < 20; i++) drive(logic'((i >> 1) & 1));
      release_reset();
      p0 = pulses;
      tone(452, 3);
      quiet(T + 50);
      chk("no_pulse_before_4_rises", 32'(pulses - p0), 32'd0);

      // Single Cs5 lock, then timeout to silence.
      p0 = pulses;
      rise_cyc.delete();
      tone(452, 6);
      chk("cs5_pulse_count", 32'(pulses - p0), 32'd1);
      chk("cs5_code", 32'(note_code), 32'd3);
      chk("cs5_period", period, 32'd452);
      chk("cs5_latency", 32'(last_pulse_cyc - rise_cyc[3]), 32'd5);
      quiet(T + 50);
      chk("silence_pulse_count", 32'(pulses - p0), 32'd2);
      chk("silence_code", 32'(note_code), 32'd0);
      chk("silence_period", period, 32'd0);
      chk("silence_active", 32'(tone_active), 32'd0);

      // Note change, then a one-period glitch.
      p0 = pulses;
      tone(452, 5);
      tone(301, 5);
      chk("change_pulses", 32'(pulses - p0), 32'd2);
      chk("change_code", 32'(note_code), 32'd7);
      p0 = pulses;
      tone(452, 4);
      tone(301, 1);
      tone(452, 4);
      chk("glitch_pulses", 32'(pulses - p0), 32'd1);
      chk("glitch_code", 32'(note_code), 32'd3);
      quiet(T + 50);

      // Out-of-table periods.
      tone(120, 4);
      chk("below_min_code", 32'(note_code), 32'd15);
      quiet(T + 50);
      tone(465, 4);
      chk("between_code", 32'(note_code), 32'd15);
      chk("between_period", period, 32'd465);
      quiet(T + 50);

      // Random bursts with gaps straddling the timeout boundary.
      for (int b = 0; b < 7; b++) begin
         k = $urandom_range(0, 8);
         if (k == 0)      per = $urandom_range(125, 700);
         else if (k == 8) per = $urandom_range(20, 124);
         else begin
            tol = nom(k) >> TOL_SHIFT;
            per = nom(k) - tol / 2 + $urandom_range(0, 2 * (tol / 2));
         end
         n = $urandom_range(1, 5);
         tone(per, n);
         g = $urandom_range(0, 2);
         quiet((g == 0 ? T + 1 : (g == 1 ? T + 2 : T + 60)) - per);
      end
      quiet(T + 50);

      // Asynchronous reset in the middle of a locked period.
      tone(452, 5);
      tone_in = 1'b1;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(note_valid), 32'd0);
      chk("async_rst_code", 32'(note_code), 32'd0);
      chk("async_rst_period", period, 32'd0);
      chk("async_rst_active", 32'(tone_active), 32'd0);
      model_reset();
      for (int i = 0; i < 6; i++) drive(logic'(i & 1));
      release_reset();
      p0 = pulses;
      rise_cyc.delete();
      tone(452, 6);
      chk("relock_pulse_count", 32'(pulses - p0), 32'd1);
      chk("relock_code", 32'(note_code), 32'd3);
      chk("relock_latency", 32'(last_pulse_cyc - rise_cyc[3]), 32'd5);
      quiet(T + 50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
